// File: rtl/rv_regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_regfile_sb_pkg
// Purpose : Shared constants and helpers for the integer register file with
//           scoreboard: default data width, register address width, ABI
//           register indices and a population-count function.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rv_regfile_sb_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_AW       = 5;

    // ABI register indices
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd1;
    localparam logic [REG_AW-1:0] REG_SP   = 5'd2;

    // Number of set bits in a vector of up to 64 bits (zero-extend narrower ones).
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module  : rv_regfile_sb_if
// Purpose : Bundle of the decode/writeback signals seen by the register file.
//           master = pipeline side (decode + writeback), slave = register file.
// Ports   : RA1/RA2 read addresses, RD1/RD2 read data, WE/WADDR/WDATA
//           writeback, ISSUE_VAL/USE_RS1/USE_RS2/ISSUE_RD issue request,
//           ISSUE_RDY issue accept, FLUSH, BUSY_CNT, WB_ORPHAN.
// Revision: 1.0 - initial release
// ============================================================================
interface rv_regfile_sb_if
    import rv_regfile_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   RA1;
    logic [AW-1:0]   RA2;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic            WE;
    logic [AW-1:0]   WADDR;
    logic [XLEN-1:0] WDATA;
    logic            ISSUE_VAL;
    logic            USE_RS1;
    logic            USE_RS2;
    logic [AW-1:0]   ISSUE_RD;
    logic            ISSUE_RDY;
    logic            FLUSH;
    logic [AW:0]     BUSY_CNT;
    logic            WB_ORPHAN;

    modport master (
        output RA1, RA2, WE, WADDR, WDATA, ISSUE_VAL, USE_RS1, USE_RS2,
               ISSUE_RD, FLUSH,
        input  RD1, RD2, ISSUE_RDY, BUSY_CNT, WB_ORPHAN
    );

    modport slave (
        input  RA1, RA2, WE, WADDR, WDATA, ISSUE_VAL, USE_RS1, USE_RS2,
               ISSUE_RD, FLUSH,
        output RD1, RD2, ISSUE_RDY, BUSY_CNT, WB_ORPHAN
    );

endinterface
`default_nettype wire

// File: rtl/rv_regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : rv_regfile_sb_scoreboard
// Purpose : Per-register busy tracking. Stalls issue on RAW/WAW hazards,
//           keeps a registered count of busy registers and a sticky flag
//           for writebacks that hit a register nobody was waiting on.
// Ports   : CLK, RST (async active-low); ra1/ra2/use_rs1/use_rs2/issue_val/
//           issue_rd issue request; we/waddr writeback; flush;
//           issue_rdy, busy_cnt, wb_orphan outputs.
// Revision: 1.0 - initial release
// ============================================================================
module rv_regfile_sb_scoreboard
    import rv_regfile_sb_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter bit BYPASS = 1'b1
)(
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          use_rs1,
    input  logic          use_rs2,
    input  logic          issue_val,
    input  logic [AW-1:0] issue_rd,
    input  logic          flush,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    output logic          issue_rdy,
    output logic [AW:0]   busy_cnt,
    output logic          wb_orphan
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     busy_cnt_q, busy_cnt_d;
    logic            wb_orphan_q, wb_orphan_d;

    logic [NREG-1:0] wb_onehot;
    logic [NREG-1:0] pend_vec;
    logic            wb_valid;
    logic            rd_valid;
    logic            rs1_pend, rs2_pend, rd_pend;
    logic            hazard;
    logic            accept;

    // x0 and addresses beyond NREG never take part in tracking.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    assign wb_valid = we && addr_ok(waddr);
    assign rd_valid = addr_ok(issue_rd);

    always_comb begin
        wb_onehot = '0;
        if (wb_valid) begin
            wb_onehot[waddr] = 1'b1;
        end
    end

    // With forwarding, a register being written back this cycle is already
    // resolved for anyone reading it now.
    assign pend_vec = BYPASS ? (busy_q & ~wb_onehot) : busy_q;

    assign rs1_pend = addr_ok(ra1)      && pend_vec[ra1];
    assign rs2_pend = addr_ok(ra2)      && pend_vec[ra2];
    assign rd_pend  = rd_valid          && pend_vec[issue_rd];

    assign hazard    = (use_rs1 && rs1_pend) || (use_rs2 && rs2_pend) || rd_pend;
    assign accept    = issue_val && !hazard && !flush;
    assign issue_rdy = accept;

    always_comb begin
        busy_d      = busy_q;
        wb_orphan_d = wb_orphan_q;
        if (flush) begin
            busy_d      = '0;
            wb_orphan_d = 1'b0;
        end else begin
            if (wb_valid) begin
                busy_d[waddr] = 1'b0;
                if (!busy_q[waddr]) begin
                    wb_orphan_d = 1'b1;
                end
            end
            // Applied after the clear so a new producer wins over the
            // retiring one on the same register.
            if (accept && rd_valid) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
        busy_cnt_d = (AW+1)'(popcount(64'(busy_d)));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy_q      <= '0;
            busy_cnt_q  <= '0;
            wb_orphan_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            busy_cnt_q  <= busy_cnt_d;
            wb_orphan_q <= wb_orphan_d;
        end
    end

    assign busy_cnt  = busy_cnt_q;
    assign wb_orphan = wb_orphan_q;

endmodule
`default_nettype wire

// File: rtl/rv_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module  : rv_regfile_sb
// Purpose : Integer register file for the pipelined RV32I/RV64I core with two
//           asynchronous read ports, one synchronous write port, x0 tied to
//           zero, optional writeback-to-read forwarding and a busy scoreboard.
// Ports   : CLK       - clock, rising edge
//           RST       - asynchronous active-low reset
//           bus       - rv_regfile_sb_if.slave: read ports, writeback,
//                       issue handshake, FLUSH, BUSY_CNT, WB_ORPHAN
// Revision: 1.0 - initial release
// ============================================================================
module rv_regfile_sb
    import rv_regfile_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter bit BYPASS = 1'b1
)(
    input  logic           CLK,
    input  logic           RST,
    rv_regfile_sb_if.slave bus
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wb_valid;

    assign wb_valid = bus.WE && (bus.WADDR != '0) && (int'(bus.WADDR) < NREG);

    always_comb begin
        regs_d = regs_q;
        if (wb_valid) begin
            regs_d[bus.WADDR] = bus.WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: x0 and out-of-range reads give zero; forwarding only for a
    // real (non-x0, in-range) writeback.
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [AW-1:0]   addr;
        logic            in_range;
        logic [XLEN-1:0] rd_data;

        assign addr     = (p == 0) ? bus.RA1 : bus.RA2;
        assign in_range = (addr != '0) && (int'(addr) < NREG);

        always_comb begin
            rd_data = '0;
            if (in_range) begin
                if (BYPASS && wb_valid && (bus.WADDR == addr)) begin
                    rd_data = bus.WDATA;
                end else begin
                    rd_data = regs_q[addr];
                end
            end
        end
    end

    assign bus.RD1 = g_rd_port[0].rd_data;
    assign bus.RD2 = g_rd_port[1].rd_data;

    rv_regfile_sb_scoreboard #(
        .NREG   (NREG),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .ra1       (bus.RA1),
        .ra2       (bus.RA2),
        .use_rs1   (bus.USE_RS1),
        .use_rs2   (bus.USE_RS2),
        .issue_val (bus.ISSUE_VAL),
        .issue_rd  (bus.ISSUE_RD),
        .flush     (bus.FLUSH),
        .we        (bus.WE),
        .waddr     (bus.WADDR),
        .issue_rdy (bus.ISSUE_RDY),
        .busy_cnt  (bus.BUSY_CNT),
        .wb_orphan (bus.WB_ORPHAN)
    );

endmodule
`default_nettype wire

// File: tb/tb_rv_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_regfile_sb
// Purpose : Directed self-checking bench for rv_regfile_sb. Two instances
//           (forwarding on / off) receive identical stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv_regfile_sb;
    import rv_regfile_sb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, waddr, issue_rd;
    logic [31:0] wdata;
    logic        we, issue_val, use_rs1, use_rs2, flush;

    int total;
    int bad;

    rv_regfile_sb_if #(.XLEN(32), .NREG(32)) if_b ();
    rv_regfile_sb_if #(.XLEN(32), .NREG(32)) if_n ();

    assign if_b.RA1 = ra1;          assign if_n.RA1 = ra1;
    assign if_b.RA2 = ra2;          assign if_n.RA2 = ra2;
    assign if_b.WE = we;            assign if_n.WE = we;
    assign if_b.WADDR = waddr;      assign if_n.WADDR = waddr;
    assign if_b.WDATA = wdata;      assign if_n.WDATA = wdata;
    assign if_b.ISSUE_VAL = issue_val; assign if_n.ISSUE_VAL = issue_val;
    assign if_b.USE_RS1 = use_rs1;  assign if_n.USE_RS1 = use_rs1;
    assign if_b.USE_RS2 = use_rs2;  assign if_n.USE_RS2 = use_rs2;
    assign if_b.ISSUE_RD = issue_rd; assign if_n.ISSUE_RD = issue_rd;
    assign if_b.FLUSH = flush;      assign if_n.FLUSH = flush;

    rv_regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u_dut_byp (
        .CLK (clk),
        .RST (rst_n),
        .bus (if_b)
    );

    rv_regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) u_dut_nobyp (
        .CLK (clk),
        .RST (rst_n),
        .bus (if_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ra1 = '0; ra2 = '0; we = 1'b0; waddr = '0; wdata = '0;
        issue_val = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; issue_rd = '0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) begin
            ra1 = 5'(r);
            ra2 = 5'(31 - r);
            #1;
            total++; if (if_b.RD1 !== 32'h0) begin bad++; $display("FAIL reset_rd1_byp r=%0d got=%h exp=0", r, if_b.RD1); end
            total++; if (if_b.RD2 !== 32'h0) begin bad++; $display("FAIL reset_rd2_byp r=%0d got=%h exp=0", r, if_b.RD2); end
            total++; if (if_n.RD1 !== 32'h0) begin bad++; $display("FAIL reset_rd1_nob r=%0d got=%h exp=0", r, if_n.RD1); end
            total++; if (if_n.RD2 !== 32'h0) begin bad++; $display("FAIL reset_rd2_nob r=%0d got=%h exp=0", r, if_n.RD2); end
        end
        total++; if (if_b.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL reset_cnt_byp got=%0d exp=0", if_b.BUSY_CNT); end
        total++; if (if_n.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL reset_cnt_nob got=%0d exp=0", if_n.BUSY_CNT); end
        total++; if (if_b.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL reset_orph_byp got=%b exp=0", if_b.WB_ORPHAN); end
        total++; if (if_n.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL reset_orph_nob got=%b exp=0", if_n.WB_ORPHAN); end
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = REG_ZERO; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0; ra1 = REG_ZERO;
        #1;
        total++; if (if_b.RD1 !== 32'h0) begin bad++; $display("FAIL x0_read_byp got=%h exp=0", if_b.RD1); end
        total++; if (if_n.RD1 !== 32'h0) begin bad++; $display("FAIL x0_read_nob got=%h exp=0", if_n.RD1); end
        total++; if (if_b.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL x0_orph_byp got=%b exp=0", if_b.WB_ORPHAN); end
        we = 1'b1; waddr = 5'd5; wdata = 32'h0000_1234;
        tick();
        we = 1'b0; ra1 = 5'd5;
        #1;
        total++; if (if_b.RD1 !== 32'h1234) begin bad++; $display("FAIL x5_read_byp got=%h exp=00001234", if_b.RD1); end
        total++; if (if_n.RD1 !== 32'h1234) begin bad++; $display("FAIL x5_read_nob got=%h exp=00001234", if_n.RD1); end
        total++; if (if_b.WB_ORPHAN !== 1'b1) begin bad++; $display("FAIL x5_orph_byp got=%b exp=1", if_b.WB_ORPHAN); end
        total++; if (if_n.WB_ORPHAN !== 1'b1) begin bad++; $display("FAIL x5_orph_nob got=%b exp=1", if_n.WB_ORPHAN); end
        idle();
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111;
        tick();
        wdata = 32'hA5A5_A5A5; ra2 = 5'd7; ra1 = 5'd0;
        #1;
        total++; if (if_b.RD2 !== 32'hA5A5A5A5) begin bad++; $display("FAIL fwd_rd2_byp got=%h exp=a5a5a5a5", if_b.RD2); end
        total++; if (if_n.RD2 !== 32'h11111111) begin bad++; $display("FAIL fwd_rd2_nob got=%h exp=11111111", if_n.RD2); end
        total++; if (if_b.RD1 !== 32'h0) begin bad++; $display("FAIL fwd_rd1_x0 got=%h exp=0", if_b.RD1); end
        tick();
        we = 1'b0;
        #1;
        total++; if (if_b.RD2 !== 32'hA5A5A5A5) begin bad++; $display("FAIL after_wr_byp got=%h exp=a5a5a5a5", if_b.RD2); end
        total++; if (if_n.RD2 !== 32'hA5A5A5A5) begin bad++; $display("FAIL after_wr_nob got=%h exp=a5a5a5a5", if_n.RD2); end
        we = 1'b1; waddr = REG_ZERO; wdata = 32'hFFFF_FFFF; ra1 = REG_ZERO;
        #1;
        total++; if (if_b.RD1 !== 32'h0) begin bad++; $display("FAIL fwd_x0_byp got=%h exp=0", if_b.RD1); end
        tick();
        idle();
    endtask

    task automatic test_raw_hazard();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        total++; if (if_b.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL flush_orph_byp got=%b exp=0", if_b.WB_ORPHAN); end
        total++; if (if_n.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL flush_orph_nob got=%b exp=0", if_n.WB_ORPHAN); end
        issue_val = 1'b1; issue_rd = 5'd3;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL iss3_rdy_byp got=%b exp=1", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL iss3_rdy_nob got=%b exp=1", if_n.ISSUE_RDY); end
        tick();
        issue_rd = 5'd0; ra1 = 5'd3; use_rs1 = 1'b1;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL raw_rdy_byp got=%b exp=0", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL raw_rdy_nob got=%b exp=0", if_n.ISSUE_RDY); end
        total++; if (if_b.BUSY_CNT !== 6'd1) begin bad++; $display("FAIL raw_cnt1_byp got=%0d exp=1", if_b.BUSY_CNT); end
        total++; if (if_n.BUSY_CNT !== 6'd1) begin bad++; $display("FAIL raw_cnt1_nob got=%0d exp=1", if_n.BUSY_CNT); end
        we = 1'b1; waddr = 5'd3; wdata = 32'h33;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL wb_rdy_byp got=%b exp=1", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL wb_rdy_nob got=%b exp=0", if_n.ISSUE_RDY); end
        tick();
        we = 1'b0;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL post_rdy_byp got=%b exp=1", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL post_rdy_nob got=%b exp=1", if_n.ISSUE_RDY); end
        total++; if (if_b.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL raw_cnt0_byp got=%0d exp=0", if_b.BUSY_CNT); end
        total++; if (if_n.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL raw_cnt0_nob got=%0d exp=0", if_n.BUSY_CNT); end
        total++; if (if_n.RD1 !== 32'h33) begin bad++; $display("FAIL x3_data_nob got=%h exp=00000033", if_n.RD1); end
        total++; if (if_b.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL raw_orph_byp got=%b exp=0", if_b.WB_ORPHAN); end
        // rs2 hazard only counts when the instruction actually reads rs2
        use_rs1 = 1'b0; issue_rd = 5'd8;
        tick();
        issue_rd = 5'd0; ra2 = 5'd8; use_rs2 = 1'b0;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL rs2_unused_byp got=%b exp=1", if_b.ISSUE_RDY); end
        use_rs2 = 1'b1;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL rs2_used_byp got=%b exp=0", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL rs2_used_nob got=%b exp=0", if_n.ISSUE_RDY); end
        issue_val = 1'b0; use_rs2 = 1'b0; we = 1'b1; waddr = 5'd8; wdata = 32'h88;
        tick();
        idle();
        #1;
        total++; if (if_n.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL x8_cnt_nob got=%0d exp=0", if_n.BUSY_CNT); end
    endtask

    task automatic test_waw_same_cycle();
        issue_val = 1'b1; issue_rd = 5'd4;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL iss4_rdy_byp got=%b exp=1", if_b.ISSUE_RDY); end
        tick();
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL waw_rdy_byp got=%b exp=0", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL waw_rdy_nob got=%b exp=0", if_n.ISSUE_RDY); end
        we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL waw_wb_rdy_byp got=%b exp=1", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL waw_wb_rdy_nob got=%b exp=0", if_n.ISSUE_RDY); end
        tick();
        we = 1'b0; issue_val = 1'b0;
        #1;
        total++; if (if_b.BUSY_CNT !== 6'd1) begin bad++; $display("FAIL waw_cnt_byp got=%0d exp=1", if_b.BUSY_CNT); end
        total++; if (if_n.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL waw_cnt_nob got=%0d exp=0", if_n.BUSY_CNT); end
        total++; if (if_b.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL waw_orph_byp got=%b exp=0", if_b.WB_ORPHAN); end
        total++; if (if_n.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL waw_orph_nob got=%b exp=0", if_n.WB_ORPHAN); end
        issue_val = 1'b1; issue_rd = 5'd0; ra1 = 5'd4; use_rs1 = 1'b0;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL rd0_rdy_byp got=%b exp=1", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL rd0_rdy_nob got=%b exp=1", if_n.ISSUE_RDY); end
        tick();
        idle();
        #1;
        total++; if (if_b.BUSY_CNT !== 6'd1) begin bad++; $display("FAIL rd0_cnt_byp got=%0d exp=1", if_b.BUSY_CNT); end
        total++; if (if_n.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL rd0_cnt_nob got=%0d exp=0", if_n.BUSY_CNT); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue_val = 1'b1; issue_rd = REG_RA;
        tick();
        issue_rd = REG_SP;
        tick();
        issue_rd = 5'd9;
        tick();
        issue_val = 1'b0;
        #1;
        total++; if (if_b.BUSY_CNT !== 6'd3) begin bad++; $display("FAIL three_cnt_byp got=%0d exp=3", if_b.BUSY_CNT); end
        total++; if (if_n.BUSY_CNT !== 6'd3) begin bad++; $display("FAIL three_cnt_nob got=%0d exp=3", if_n.BUSY_CNT); end
        flush = 1'b1; issue_val = 1'b1; issue_rd = 5'd5;
        we = 1'b1; waddr = REG_SP; wdata = 32'h22;
        #1;
        total++; if (if_b.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL flush_rdy_byp got=%b exp=0", if_b.ISSUE_RDY); end
        total++; if (if_n.ISSUE_RDY !== 1'b0) begin bad++; $display("FAIL flush_rdy_nob got=%b exp=0", if_n.ISSUE_RDY); end
        tick();
        idle();
        ra1 = REG_SP;
        #1;
        total++; if (if_b.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL flush_cnt_byp got=%0d exp=0", if_b.BUSY_CNT); end
        total++; if (if_n.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL flush_cnt_nob got=%0d exp=0", if_n.BUSY_CNT); end
        total++; if (if_b.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL flushwb_orph_byp got=%b exp=0", if_b.WB_ORPHAN); end
        total++; if (if_n.RD1 !== 32'h22) begin bad++; $display("FAIL flushwb_data_nob got=%h exp=00000022", if_n.RD1); end
        total++; if (if_b.RD1 !== 32'h22) begin bad++; $display("FAIL flushwb_data_byp got=%h exp=00000022", if_b.RD1); end
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        tick();
        we = 1'b0;
        #1;
        total++; if (if_b.WB_ORPHAN !== 1'b1) begin bad++; $display("FAIL x9_orph_byp got=%b exp=1", if_b.WB_ORPHAN); end
        total++; if (if_n.WB_ORPHAN !== 1'b1) begin bad++; $display("FAIL x9_orph_nob got=%b exp=1", if_n.WB_ORPHAN); end
        idle();
    endtask

    task automatic test_reset_mid();
        issue_val = 1'b1; issue_rd = 5'd6;
        tick();
        issue_val = 1'b0;
        #1;
        total++; if (if_b.BUSY_CNT !== 6'd1) begin bad++; $display("FAIL pre_rst_cnt_byp got=%0d exp=1", if_b.BUSY_CNT); end
        rst_n = 1'b0;
        ra1 = 5'd5; ra2 = 5'd9;
        issue_val = 1'b1; issue_rd = 5'd6;
        #1;
        total++; if (if_b.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL rst_cnt_byp got=%0d exp=0", if_b.BUSY_CNT); end
        total++; if (if_n.BUSY_CNT !== 6'd0) begin bad++; $display("FAIL rst_cnt_nob got=%0d exp=0", if_n.BUSY_CNT); end
        total++; if (if_b.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL rst_orph_byp got=%b exp=0", if_b.WB_ORPHAN); end
        total++; if (if_n.WB_ORPHAN !== 1'b0) begin bad++; $display("FAIL rst_orph_nob got=%b exp=0", if_n.WB_ORPHAN); end
        total++; if (if_b.RD1 !== 32'h0) begin bad++; $display("FAIL rst_rd1_byp got=%h exp=0", if_b.RD1); end
        total++; if (if_n.RD2 !== 32'h0) begin bad++; $display("FAIL rst_rd2_nob got=%h exp=0", if_n.RD2); end
        total++; if (if_b.ISSUE_RDY !== 1'b1) begin bad++; $display("FAIL rst_rdy_byp got=%b exp=1", if_b.ISSUE_RDY); end
        rst_n = 1'b1;
        idle();
        tick();
        ra1 = 5'd5;
        #1;
        total++; if (if_n.RD1 !== 32'h0) begin bad++; $display("FAIL post_rst_x5_nob got=%h exp=0", if_n.RD1); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_raw_hazard();
        test_waw_same_cycle();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
